// File: rtl/fib_controller.sv
// Fibonacci sequencing controller: drives a shared 4-bit ALU one operation per cycle to compute F(n) mod 16.
// Optional sticky overflow output enabled by defining FIB_OVF_EN.
module fib_controller #(
  parameter int size = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [size-1:0] n_in,
  input  logic [size-1:0] alu_out,
  input  logic            alu_zero,
  output logic [size-2:0] opcode,
  output logic [size-1:0] alu_a,
  output logic [size-1:0] alu_b,
  output logic [size-1:0] result,
  output logic            busy,
  output logic            done
`ifdef FIB_OVF_EN
  ,
  output logic            ovf
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    INIT = 3'd2,
    DEC  = 3'd3,
    ADD  = 3'd4,
    SWAP = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_ONE    = 3'b001;
  localparam logic [2:0] OP_DEC    = 3'b011;
  localparam logic [2:0] OP_PASS_A = 3'b100;
  localparam logic [2:0] OP_ADD    = 3'b110;
  localparam logic [2:0] OP_PASS_B = 3'b111;

  state_t          state, state_next;
  logic [size-1:0] n_q, cnt, a_reg, b_reg, t_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      n_q    <= '0;
      cnt    <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      t_reg  <= '0;
      result <= '0;
`ifdef FIB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            n_q <= n_in;
`ifdef FIB_OVF_EN
            ovf <= 1'b0;
`endif
          end
        end
        LOAD: begin
          cnt <= alu_out;
          if (alu_zero) result <= '0;
        end
        INIT: begin
          b_reg <= alu_out;
          a_reg <= '0;
        end
        DEC: begin
          cnt <= alu_out;
          if (alu_zero) result <= b_reg;
        end
        ADD: begin
          t_reg <= alu_out;
`ifdef FIB_OVF_EN
          // A wrapped modulo sum is always smaller than either addend
          ovf   <= ovf | (alu_out < a_reg);
`endif
        end
        SWAP: begin
          a_reg <= alu_out;
          b_reg <= t_reg;
        end
        default: ;
      endcase
    end
  end

  // ALU controls are Moore outputs; only the next state looks at the ALU result
  always_comb begin
    state_next = state;
    opcode     = OP_NOP;
    alu_a      = '0;
    alu_b      = '0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = LOAD;
      end
      LOAD: begin
        opcode     = OP_PASS_A;
        alu_a      = n_q;
        state_next = alu_zero ? DONE : INIT;
      end
      INIT: begin
        opcode     = OP_ONE;
        state_next = DEC;
      end
      DEC: begin
        opcode     = OP_DEC;
        alu_a      = cnt;
        state_next = alu_zero ? DONE : ADD;
      end
      ADD: begin
        opcode     = OP_ADD;
        alu_a      = a_reg;
        alu_b      = b_reg;
        state_next = SWAP;
      end
      SWAP: begin
        opcode     = OP_PASS_B;
        alu_b      = b_reg;
        state_next = DEC;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fib_controller.sv
// Self-checking bench for fib_controller with a behavioural ALU and a Fibonacci reference model.
// Checks ovf as well when compiled with FIB_OVF_EN.
module tb_fib_controller;

  typedef struct {
    logic [3:0] n;
    int         exp_result;
    int         exp_cycle;
    int         exp_ovf;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] n_in;
  logic [3:0] alu_out;
  logic       alu_zero;
  logic [2:0] opcode;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] result;
  logic       busy;
  logic       done;
`ifdef FIB_OVF_EN
  logic       ovf;
`endif

  int errors = 0;
  int checks = 0;
  logic [2:0] op_trace [0:64];

  fib_controller #(.size(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .n_in     (n_in),
    .alu_out  (alu_out),
    .alu_zero (alu_zero),
    .opcode   (opcode),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .result   (result),
    .busy     (busy),
    .done     (done)
`ifdef FIB_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU sitting downstream of the controller
  always_comb begin
    case (opcode)
      3'b100:  alu_out = alu_a;
      3'b001:  alu_out = 4'd1;
      3'b011:  alu_out = alu_a - 4'd1;
      3'b110:  alu_out = alu_a + alu_b;
      3'b111:  alu_out = alu_b;
      default: alu_out = 4'd0;
    endcase
    alu_zero = (alu_out == 4'd0);
  end

  function automatic int fibTrue(input int n);
    int a, b, t;
    a = 0;
    b = 1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Runs one computation; returns the done cycle (edge 0 = accepting edge) and final result
  task automatic applyStimulus(input logic [3:0] n, output int done_cyc, output int res);
    int guard;
    int prev;
    guard = 0;
    while (busy && guard < 64) begin
      @(posedge clk); #1;
      guard++;
    end
    if (busy) checkOutput("idle_wait_timeout", 1, 0);
    prev  = int'(result);
    start = 1'b1;
    n_in  = n;
    @(posedge clk); #1;
    start = 1'b0;
    n_in  = 4'($urandom);
    done_cyc = -1;
    for (int k = 1; k <= 64; k++) begin
      op_trace[k] = opcode;
      if (k == 1) begin
        checkOutput("busy_cycle1", int'(busy), 1);
        checkOutput("result_held", int'(result), prev);
`ifdef FIB_OVF_EN
        checkOutput("ovf_cleared_on_start", int'(ovf), 0);
`endif
      end
      if (done) begin
        done_cyc = k;
        break;
      end
      @(posedge clk); #1;
    end
    if (done_cyc < 0) checkOutput("done_timeout", 0, 1);
    res = int'(result);
`ifdef FIB_OVF_EN
    checkOutput("ovf_flag", int'(ovf), (fibTrue(int'(n)) > 15) ? 1 : 0);
`endif
    @(posedge clk); #1;
    checkOutput("done_one_cycle", int'(done), 0);
    checkOutput("idle_after_done", int'(busy), 0);
  endtask

  initial begin
    vec_t vecs [6];
    int   cyc, res, nr, seen;

    vecs[0] = '{n: 4'd0,  exp_result: 0,  exp_cycle: 2,  exp_ovf: 0};
    vecs[1] = '{n: 4'd1,  exp_result: 1,  exp_cycle: 4,  exp_ovf: 0};
    vecs[2] = '{n: 4'd7,  exp_result: 13, exp_cycle: 22, exp_ovf: 0};
    vecs[3] = '{n: 4'd8,  exp_result: 5,  exp_cycle: 25, exp_ovf: 1};
    vecs[4] = '{n: 4'd2,  exp_result: 1,  exp_cycle: 7,  exp_ovf: 0};
    vecs[5] = '{n: 4'd15, exp_result: 2,  exp_cycle: 46, exp_ovf: 1};

    rst_n = 1'b0;
    start = 1'b0;
    n_in  = 4'd0;
    #1;
    checkOutput("reset_busy",   int'(busy),   0);
    checkOutput("reset_done",   int'(done),   0);
    checkOutput("reset_opcode", int'(opcode), 0);
    checkOutput("reset_alu_a",  int'(alu_a),  0);
    checkOutput("reset_alu_b",  int'(alu_b),  0);
    checkOutput("reset_result", int'(result), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].n, cyc, res);
      checkOutput($sformatf("vec%0d_done_cycle", i), cyc, vecs[i].exp_cycle);
      checkOutput($sformatf("vec%0d_result", i), res, vecs[i].exp_result);
      if (i == 0) begin
        checkOutput("n0_op_c1", int'(op_trace[1]), 4);
        checkOutput("n0_op_c2", int'(op_trace[2]), 0);
      end
      if (i == 1) begin
        checkOutput("n1_op_c1", int'(op_trace[1]), 4);
        checkOutput("n1_op_c2", int'(op_trace[2]), 1);
        checkOutput("n1_op_c3", int'(op_trace[3]), 3);
        checkOutput("n1_op_c4", int'(op_trace[4]), 0);
      end
`ifdef FIB_OVF_EN
      checkOutput($sformatf("vec%0d_ovf", i), int'(ovf), vecs[i].exp_ovf);
`endif
    end

    // start held high with n_in toggling: only the first captured n matters
    start = 1'b1;
    n_in  = 4'd3;
    @(posedge clk); #1;
    cyc = -1;
    for (int k = 1; k <= 64; k++) begin
      n_in = ~n_in;
      if (done) begin
        cyc = k;
        break;
      end
      checkOutput("hold_busy", int'(busy), 1);
      @(posedge clk); #1;
    end
    checkOutput("hold_done_cycle", cyc, 10);
    checkOutput("hold_result", int'(result), 2);
    n_in = 4'd2;
    @(posedge clk); #1;
    checkOutput("hold_dead_cycle", int'(busy), 0);
    @(posedge clk); #1;
    checkOutput("hold_reaccept_busy", int'(busy), 1);
    checkOutput("hold_reaccept_op", int'(opcode), 4);
    checkOutput("hold_reaccept_n", int'(alu_a), 2);
    start = 1'b0;
    seen  = 0;
    for (int k = 0; k < 64 && !seen; k++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    checkOutput("hold_second_done", seen, 1);
    checkOutput("hold_second_result", int'(result), 1);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of the first ADD of an n=6 run
    start = 1'b1;
    n_in  = 4'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("midrun_in_add", int'(opcode), 6);
    checkOutput("midrun_add_b", int'(alu_b), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_busy",   int'(busy),   0);
    checkOutput("async_opcode", int'(opcode), 0);
    checkOutput("async_alu_a",  int'(alu_a),  0);
    checkOutput("async_alu_b",  int'(alu_b),  0);
    checkOutput("async_result", int'(result), 0);
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    checkOutput("aborted_run_no_done", seen, 0);
    applyStimulus(4'd6, cyc, res);
    checkOutput("post_reset_cycle", cyc, 19);
    checkOutput("post_reset_result", res, 8);

    // Random indices against the reference model
    for (int i = 0; i < 20; i++) begin
      nr = int'($urandom_range(0, 15));
      applyStimulus(4'(nr), cyc, res);
      checkOutput($sformatf("rand%0d_n%0d_result", i, nr), res, fibTrue(nr) % 16);
      checkOutput($sformatf("rand%0d_n%0d_cycle", i, nr), cyc, (nr == 0) ? 2 : 3 * nr + 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fib_controller.md
# fib_controller

Sequencing controller for the Fibonacci datapath. On each `start` request it computes F(n) for a 4-bit `n` by driving the shared 4-bit ALU's operands and opcode, one ALU operation per cycle. It sits directly upstream of the ALU, consumes the ALU's `out` and `zero_flag` back into its own registers, and presents the final value with a one-cycle `done` pulse.

## Interface
- `size`, 4, datapath width. Only 4 is supported, because the ALU zero flag covers exactly bits [3:0]. The opcode width is `size-1`.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request. Sampled only in IDLE.
- `n_in`  in  size  index n. Captured into `n_q` on the accepting edge.
- `alu_out`  in  size  ALU `out`
- `alu_zero`  in  1  ALU `zero_flag`
- `opcode`  out  size-1  ALU opcode
- `alu_a`  out  size  ALU Input1
- `alu_b`  out  size  ALU Input2
- `result`  out  size  F(n) mod 16. Holds until the next accepted `start`.
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse in DONE
- `ovf`  out  1  sticky overflow. Present only with `FIB_OVF_EN`.

## Operation
- Internal registers: `n_q`, `cnt`, `A`, `B`, `T` (each `size` bits), plus the state register.
- `opcode`, `alu_a` and `alu_b` are combinational from state only (Moore). All register updates occur on `clk` rising edges.
- IDLE: opcode 000, alu_a = alu_b = 0.
  - When `start` = 1: `n_q` <= `n_in`; go to LOAD.
- LOAD: opcode 100, alu_a = `n_q`.
  - `cnt` <= `alu_out`.
  - If `alu_zero`: `result` <= 0, go to DONE. Otherwise go to INIT.
- INIT: opcode 001.
  - `B` <= `alu_out` (= 1), `A` <= 0.
  - Go to DEC.
- DEC: opcode 011, alu_a = `cnt`.
  - `cnt` <= `alu_out`.
  - If `alu_zero`: `result` <= `B`, go to DONE. Otherwise go to ADD.
- ADD: opcode 110, alu_a = `A`, alu_b = `B`.
  - `T` <= `alu_out`.
  - Go to SWAP.
- SWAP: opcode 111, alu_b = `B`.
  - `A` <= `alu_out` (= old B), `B` <= `T`.
  - Go to DEC.
- DONE: opcode 000, `done` = 1.
  - Go to IDLE unconditionally.
- Arithmetic is unsigned modulo 2^size. The ADD result wraps silently.
- `start` outside IDLE is ignored and is not queued. `start` held high in DONE is not accepted until IDLE.
- `n_in` changes after the accepting edge have no effect on the current run.
- An unused state encoding returns to IDLE on the next edge.
- Reset (asynchronous, any state, including mid-computation):
  - State goes to IDLE.
  - `n_q`, `cnt`, `A`, `B`, `T`, `result` are cleared to 0.
  - `done` = 0, `busy` = 0, `ovf` = 0, `opcode` = 000, `alu_a` = `alu_b` = 0.

## Timing
- Number cycles from the edge that accepts `start` as edge 0.
- n = 0: LOAD occupies cycle 1. `done` is high in cycle 2.
- n ≥ 1: `done` is high in cycle 3n+1 (LOAD, INIT, then (n-1)×(DEC, ADD, SWAP), then the final DEC).
- `result` is valid from the start of the DONE cycle.
- `busy` rises the cycle after acceptance and falls when the state returns to IDLE.
- The earliest next accept is the first IDLE cycle after DONE, which gives one dead cycle between runs.

## Configuration
- `FIB_OVF_EN` defined:
  - `ovf` port exists.
  - In ADD, `ovf` <= `ovf` | (`alu_out` < `A`).
  - `ovf` is cleared on the accepting `start` edge and on reset.
- `FIB_OVF_EN` undefined:
  - No `ovf` port and no overflow logic.
  - All other behaviour is identical.

## Test plan
- Reset, then `n_in` = 0 with `start` pulse → `busy` 1 in cycle 1, `done` in cycle 2, `result` = 0, opcode sequence 100 then 000.
- `n_in` = 1 → `done` in cycle 4, `result` = 1, opcode sequence 100, 001, 011, 000.
- `n_in` = 7 → `done` in cycle 22, `result` = 13 (0xD); with `FIB_OVF_EN`, `ovf` = 0.
- `n_in` = 8 → `done` in cycle 25, `result` = 5 (21 mod 16); with `FIB_OVF_EN`, `ovf` = 1, then cleared by the next `start` (n = 2 → `result` 1, `ovf` 0).
- `start` = 1 held continuously with `n_in` toggling during a run with n = 3 → no re-accept before IDLE, `result` = 2 from the originally captured n, the next run is accepted on the first IDLE edge.
- `rst_n` asserted low asynchronously mid-ADD during n = 6 → outputs take reset values immediately with no clock, `done` is never pulsed for that run, and a subsequent n = 6 run gives `result` = 8 at cycle 19.
